// File: rtl/cmos_cap_pkg.sv
// Shared types and widths for the CMOS frame capture path.
package cmos_cap_pkg;

   localparam int PIX_W  = 13;
   localparam int ADDR_W = 24;
   localparam int WORD_W = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SKIP    = 2'd1,
      CAPTURE = 2'd2
   } state_e;

   // Word address after a write; a zero-sized frame keeps the address pinned at 0.
   function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                   input logic [ADDR_W-1:0] max_words);
      logic [ADDR_W-1:0] nxt;
      nxt = addr + ADDR_W'(1);
      if (max_words == '0)
         nxt = '0;
      else if (addr == max_words - ADDR_W'(1))
         nxt = '0;
      return nxt;
   endfunction

endpackage

// File: rtl/cmos_frame_capture_byte_pack.sv
// Packs consecutive href-qualified camera bytes into RGB565 words (first byte high).
module cmos_byte_pack
   import cmos_cap_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en_i,
   input  logic              href_i,
   input  logic [7:0]        data_i,
   output logic [WORD_W-1:0] word_o,
   output logic              vld_o,
   output logic              odd_o
);

   logic              toggle_q, toggle_d;
   logic [7:0]        hi_q, hi_d;
   logic              vld_q, vld_d;
   logic [WORD_W-1:0] word_q, word_d;
   logic              take;

   assign take = en_i & href_i;

   always_comb begin
      toggle_d = take & ~toggle_q;
      hi_d     = hi_q;
      vld_d    = take & toggle_q;
      word_d   = word_q;
      if (take && !toggle_q)
         hi_d = data_i;
      if (vld_d)
         word_d = {hi_q, data_i};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         toggle_q <= 1'b0;
         hi_q     <= '0;
         vld_q    <= 1'b0;
         word_q   <= '0;
      end else begin
         toggle_q <= toggle_d;
         hi_q     <= hi_d;
         vld_q    <= vld_d;
         word_q   <= word_d;
      end
   end

   // A still-set toggle when href drops means the line carried an odd byte count.
   assign odd_o  = toggle_q;
   assign vld_o  = vld_q;
   assign word_o = word_q;

endmodule

// File: rtl/cmos_frame_capture.sv
// Camera frame capture: warm-up frame skip, RGB565 packing, wrapping SDRAM
// write addresses and per-frame geometry check.
module cmos_frame_capture
   import cmos_cap_pkg::*;
#(
   parameter int WAIT_FRAMES = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_done,
   input  logic [PIX_W-1:0]  cmos_h_pixel,
   input  logic [PIX_W-1:0]  cmos_v_pixel,
   input  logic [ADDR_W-1:0] sdram_max_addr,
   input  logic              cam_vsync,
   input  logic              cam_href,
   input  logic [7:0]        cam_data,
   output logic              capture_valid,
   output logic              wr_en,
   output logic [WORD_W-1:0] wr_data,
   output logic [ADDR_W-1:0] wr_addr,
   output logic              frame_start,
   output logic              frame_done,
   output logic              size_err
);

   state_e            state_q, state_d;
   logic              vs_q, vs_prev_q, href_q, href_prev_q;
   logic [7:0]        data_q;
   logic [7:0]        skip_q, skip_d;
   logic [PIX_W-1:0]  h_q, v_q;
   logic [ADDR_W-1:0] max_q;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [PIX_W-1:0]  pix_q, pix_d, line_q, line_d;
   logic              bad_q, bad_d;
   logic              fs_q, fs_d, fd_q, fd_d, err_q, err_d;

   logic              boundary, line_end, active, enter, restart;
   logic [PIX_W-1:0]  line_pix;
   logic              line_bad;
   logic              pk_vld, pk_odd;
   logic [WORD_W-1:0] pk_word;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vs_q        <= 1'b0;
         vs_prev_q   <= 1'b0;
         href_q      <= 1'b0;
         href_prev_q <= 1'b0;
         data_q      <= '0;
      end else begin
         vs_q        <= cam_vsync;
         vs_prev_q   <= vs_q;
         href_q      <= cam_href;
         href_prev_q <= href_q;
         data_q      <= cam_data;
      end
   end

   assign boundary = vs_q & ~vs_prev_q;
   assign line_end = href_prev_q & ~href_q;
   assign active   = (state_q == CAPTURE) & cfg_done;
   assign enter    = (state_q == SKIP) & cfg_done & boundary & (skip_q == 8'(WAIT_FRAMES));
   assign restart  = enter | (active & boundary);

   // The last word of a line can land in the same cycle its href fall is seen.
   assign line_pix = pix_q + PIX_W'(pk_vld);
   assign line_bad = (line_pix != h_q) | pk_odd;

   cmos_byte_pack u_pack (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (active),
      .href_i (href_q),
      .data_i (data_q),
      .word_o (pk_word),
      .vld_o  (pk_vld),
      .odd_o  (pk_odd)
   );

   always_comb begin
      state_d = state_q;
      skip_d  = skip_q;
      addr_d  = addr_q;
      pix_d   = pix_q;
      line_d  = line_q;
      bad_d   = bad_q;
      fs_d    = 1'b0;
      fd_d    = 1'b0;
      err_d   = 1'b0;

      if (!cfg_done) begin
         state_d = IDLE;
         skip_d  = '0;
         addr_d  = '0;
         pix_d   = '0;
         line_d  = '0;
         bad_d   = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = SKIP;
               skip_d  = '0;
            end
            SKIP: begin
               if (enter) begin
                  state_d = CAPTURE;
                  skip_d  = '0;
               end else if (boundary) begin
                  skip_d = skip_q + 8'd1;
               end
            end
            CAPTURE: state_d = CAPTURE;
            default: state_d = IDLE;
         endcase

         if (restart) begin
            fs_d   = 1'b1;
            fd_d   = active;
            err_d  = active & (bad_q | (line_end & line_bad) |
                               ((line_q + PIX_W'(line_end)) != v_q));
            addr_d = '0;
            pix_d  = '0;
            line_d = '0;
            bad_d  = 1'b0;
         end else if (active) begin
            if (pk_vld)
               addr_d = next_addr(addr_q, max_q);
            if (line_end) begin
               pix_d  = '0;
               line_d = line_q + PIX_W'(1);
               bad_d  = bad_q | line_bad;
            end else if (pk_vld) begin
               pix_d = pix_q + PIX_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         skip_q  <= '0;
         addr_q  <= '0;
         pix_q   <= '0;
         line_q  <= '0;
         bad_q   <= 1'b0;
         fs_q    <= 1'b0;
         fd_q    <= 1'b0;
         err_q   <= 1'b0;
         h_q     <= '0;
         v_q     <= '0;
         max_q   <= '0;
      end else begin
         state_q <= state_d;
         skip_q  <= skip_d;
         addr_q  <= addr_d;
         pix_q   <= pix_d;
         line_q  <= line_d;
         bad_q   <= bad_d;
         fs_q    <= fs_d;
         fd_q    <= fd_d;
         err_q   <= err_d;
         // Geometry is sampled only at frame start so mid-frame changes wait a frame.
         if (restart) begin
            h_q   <= cmos_h_pixel;
            v_q   <= cmos_v_pixel;
            max_q <= sdram_max_addr;
         end
      end
   end

   assign capture_valid = (state_q == CAPTURE);
   assign wr_en         = pk_vld;
   assign wr_data       = pk_word;
   assign wr_addr       = addr_q;
   assign frame_start   = fs_q;
   assign frame_done    = fd_q;
   assign size_err      = err_q;

endmodule
